fwd_hazard_ctrl: RTL and testbench

- Parametrised forwarding and hazard controller for the 5-stage core: IF, ID, EX, MEM, WB.
- Compares ID-stage source registers against in-flight EX and MEM destinations and registers per-source forwarding selects into the EX stage.
- Detects load-use and no-forward RAW hazards, and issues a one-cycle stall with a bubble.
- Freezes the whole pipeline while a load waits on memory, with a timeout error and a stall-cycle counter.

---
 rtl/fwd_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding and hazard control for the 5-stage core.
// Registers per-operand EX bypass selects; raises stall for RAW hazards and freeze on memory wait.

module fwd_src_cmp #(
  parameter int REG_AW = 4
) (
  input  logic              src_vld,
  input  logic [REG_AW-1:0] src,
  input  logic              ex_wb_en,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              mem_wb_en,
  input  logic [REG_AW-1:0] mem_dest,
  output logic              match_ex,
  output logic              match_mem,
  output logic [1:0]        sel_nxt
);
  assign match_ex  = src_vld & ex_wb_en  & (src == ex_dest);
  assign match_mem = src_vld & mem_wb_en & (src == mem_dest);

  // EX producer is newer than MEM, so it wins; it sits in MEM when this op reaches EX.
  always_comb begin
    sel_nxt = 2'b00;
    if (match_ex)       sel_nxt = 2'b01;
    else if (match_mem) sel_nxt = 2'b10;
  end
endmodule

module fwd_hazard_ctrl #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fwd_en,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_vld,
  input  logic                      ex_wb_en,
  input  logic                      ex_mem_rd,
  input  logic [REG_AW-1:0]         ex_dest,
  input  logic                      mem_wb_en,
  input  logic                      mem_rd,
  input  logic                      mem_ready,
  input  logic [REG_AW-1:0]         mem_dest,
  output logic [NUM_SRC*2-1:0]      ex_sel,
  output logic                      stall,
  output logic                      freeze,
  output logic                      mem_timeout,
  output logic [CNT_W-1:0]          stall_cnt
);
  localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TO_V  = WCNT_W'(TIMEOUT);
  localparam logic [WCNT_W-1:0] ONE_V = WCNT_W'(1);
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [NUM_SRC-1:0][REG_AW-1:0] src_a;
  logic [NUM_SRC-1:0][1:0]        sel_nxt, sel_q;
  logic [NUM_SRC-1:0]             match_ex, match_mem;
  logic                           hazard;
  logic [0:0]                     state;
  logic [WCNT_W-1:0]              wcnt;

  assign src_a = id_src;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_cmp #(.REG_AW(REG_AW)) u_cmp (
      .src_vld   (id_src_vld[g]),
      .src       (src_a[g]),
      .ex_wb_en  (ex_wb_en),
      .ex_dest   (ex_dest),
      .mem_wb_en (mem_wb_en),
      .mem_dest  (mem_dest),
      .match_ex  (match_ex[g]),
      .match_mem (match_mem[g]),
      .sel_nxt   (sel_nxt[g])
    );
  end

  assign hazard = (|(match_ex & {NUM_SRC{ex_mem_rd}})) |
                  (~fwd_en & ((|match_ex) | (|match_mem)));

  // Gated by reset so that all outputs read zero while reset is held.
  assign freeze = rst_n & mem_rd & ~mem_ready;
  assign stall  = rst_n & hazard & ~freeze;
  assign ex_sel = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                sel_q <= '0;
    else if (freeze)           sel_q <= sel_q;
    else if (stall || !fwd_en) sel_q <= '0;
    else                       sel_q <= sel_nxt;
  end

  // Wait counter saturates at TIMEOUT; the error flag is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (freeze) begin
            state <= ST_WAIT;
            wcnt  <= ONE_V;
            if (TO_V == ONE_V) mem_timeout <= 1'b1;
          end
        end
        default: begin
          if (mem_ready) begin
            state <= ST_RUN;
            wcnt  <= '0;
          end else if (wcnt != TO_V) begin
            wcnt <= wcnt + ONE_V;
            if (wcnt + ONE_V == TO_V) mem_timeout <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                stall_cnt <= '0;
    else if ((stall | freeze) && ~&stall_cnt)  stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench with a rule-level reference model checked every negedge.
module tb_fwd_hazard_ctrl;
  localparam int AW = 4, NS = 2, CW = 4, TO = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic fwd_en, ex_wb_en, ex_mem_rd, mem_wb_en, mem_rd, mem_ready;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0] id_src_vld;
  logic [AW-1:0] ex_dest, mem_dest;
  logic [NS*2-1:0] ex_sel;
  logic stall, freeze, mem_timeout;
  logic [CW-1:0] stall_cnt;

  int checks = 0, failures = 0;

  fwd_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .id_src(id_src), .id_src_vld(id_src_vld),
    .ex_wb_en(ex_wb_en), .ex_mem_rd(ex_mem_rd), .ex_dest(ex_dest), .mem_wb_en(mem_wb_en),
    .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_dest(mem_dest), .ex_sel(ex_sel),
    .stall(stall), .freeze(freeze), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state kept as plain integers.
  int  m_sel [NS];
  bit  m_wait, m_to;
  int  m_wcnt, m_scnt;

  function automatic int src_of(int i);
    return int'(id_src[i*AW +: AW]);
  endfunction

  function automatic bit dep_ex(int i);
    return id_src_vld[i] && ex_wb_en && src_of(i) == int'(ex_dest);
  endfunction

  function automatic bit dep_mem(int i);
    return id_src_vld[i] && mem_wb_en && src_of(i) == int'(mem_dest);
  endfunction

  function automatic bit m_hazard();
    bit h = 0;
    for (int i = 0; i < NS; i++) begin
      if (dep_ex(i) && ex_mem_rd) h = 1;
      if (!fwd_en && (dep_ex(i) || dep_mem(i))) h = 1;
    end
    return h;
  endfunction

  function automatic bit m_freeze();
    return rst_n && mem_rd && !mem_ready;
  endfunction

  function automatic bit m_stall();
    return rst_n && m_hazard() && !m_freeze();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) m_sel[i] = 0;
      m_wait = 0; m_wcnt = 0; m_to = 0; m_scnt = 0;
    end else begin
      bit fz, st;
      fz = m_freeze();
      st = m_stall();
      if (!fz)
        for (int i = 0; i < NS; i++)
          m_sel[i] = (st || !fwd_en) ? 0 : dep_ex(i) ? 1 : dep_mem(i) ? 2 : 0;
      if ((st || fz) && m_scnt < CMAX) m_scnt = m_scnt + 1;
      if (!m_wait) begin
        if (fz) begin m_wait = 1; m_wcnt = 1; end
      end else if (mem_ready) begin
        m_wait = 0; m_wcnt = 0;
      end else if (m_wcnt < TO) m_wcnt = m_wcnt + 1;
      if (m_wait && m_wcnt >= TO) m_to = 1;
    end
  end

  always @(negedge clk) begin
    logic [NS*2-1:0] e;
    for (int i = 0; i < NS; i++) e[2*i +: 2] = 2'(m_sel[i]);
    chk("m_ex_sel", 32'(ex_sel), 32'(e));
    chk("m_stall", 32'(stall), 32'(m_stall()));
    chk("m_freeze", 32'(freeze), 32'(m_freeze()));
    chk("m_timeout", 32'(mem_timeout), 32'(m_to));
    chk("m_stall_cnt", 32'(stall_cnt), 32'(m_scnt));
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    ex_wb_en = 0; ex_mem_rd = 0; ex_dest = 0; mem_wb_en = 0; mem_rd = 0;
    mem_ready = 1; mem_dest = 0; id_src = '0; id_src_vld = '0;
  endtask

  initial begin
    fwd_en = 1; quiet();
    repeat (2) @(negedge clk);
    chk("rst_ex_sel", 32'(ex_sel), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    cyc(); rst_n = 1;

    // 1: ALU result in EX forwarded via MEM path
    ex_wb_en = 1; ex_dest = 3; id_src = 8'h03; id_src_vld = 2'b01;
    @(negedge clk); chk("t1_stall", 32'(stall), 0);
    cyc(); chk("t1_sel0", 32'(ex_sel[1:0]), 1);

    // 2: load-use gives exactly one bubble, then WB-path forward
    ex_mem_rd = 1; ex_dest = 5; id_src = 8'h50; id_src_vld = 2'b10;
    @(negedge clk); chk("t2_stall", 32'(stall), 1);
    cyc(); chk("t2_bubble", 32'(ex_sel), 0);
    ex_wb_en = 0; ex_mem_rd = 0; mem_wb_en = 1; mem_dest = 5; mem_rd = 1; mem_ready = 1;
    @(negedge clk); chk("t2_nostall", 32'(stall), 0);
    cyc(); chk("t2_sel1", 32'(ex_sel[3:2]), 2); chk("t2_cnt", 32'(stall_cnt), 1);

    // 3: EX beats MEM on the same register; invalid source ignored
    quiet(); ex_wb_en = 1; ex_dest = 7; mem_wb_en = 1; mem_dest = 7;
    id_src = 8'h07; id_src_vld = 2'b01;
    cyc(); chk("t3_prio", 32'(ex_sel[1:0]), 1);
    id_src_vld = 2'b00;
    cyc(); chk("t3_novld", 32'(ex_sel[1:0]), 0);

    // 4: forwarding disabled stalls on any RAW
    quiet(); fwd_en = 0; mem_wb_en = 1; mem_dest = 2; id_src = 8'h02; id_src_vld = 2'b01;
    @(negedge clk); chk("t4_stall", 32'(stall), 1);
    cyc(); chk("t4_sel", 32'(ex_sel), 0);
    mem_wb_en = 0;
    @(negedge clk); chk("t4_clear", 32'(stall), 0);
    cyc(); fwd_en = 1;

    // 5: freeze masks a pending load-use stall and holds selects
    quiet(); mem_wb_en = 1; mem_dest = 6; id_src = 8'h60; id_src_vld = 2'b10;
    cyc(); chk("t5_pre", 32'(ex_sel), 32'h8);
    mem_rd = 1; mem_ready = 0; ex_wb_en = 1; ex_mem_rd = 1; ex_dest = 4;
    id_src = 8'h64; id_src_vld = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("t5_freeze", 32'(freeze), 1); chk("t5_nostall", 32'(stall), 0);
      cyc(); chk("t5_hold", 32'(ex_sel), 32'h8);
    end
    chk("t5_cnt", 32'(stall_cnt), 6);
    mem_ready = 1;
    @(negedge clk); chk("t5_unfrz", 32'(freeze), 0); chk("t5_stall", 32'(stall), 1);
    cyc(); chk("t5_bubble", 32'(ex_sel), 0); chk("t5_cnt2", 32'(stall_cnt), 7);

    // 6: timeout, counter saturation, async reset mid-wait
    quiet(); ex_wb_en = 1; ex_dest = 9; id_src = 8'h09; id_src_vld = 2'b01;
    cyc(); chk("t6_pre", 32'(ex_sel), 1);
    mem_rd = 1; mem_ready = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 7) chk("t6_to7", 32'(mem_timeout), 0);
      if (k == 8) chk("t6_to8", 32'(mem_timeout), 1);
    end
    chk("t6_sat", 32'(stall_cnt), CMAX);
    chk("t6_hold", 32'(ex_sel), 1);
    mem_ready = 1;
    cyc(); chk("t6_sticky", 32'(mem_timeout), 1);
    mem_ready = 0;
    cyc(); cyc();
    #1 rst_n = 0;
    #1;
    chk("t6_r_sel", 32'(ex_sel), 0); chk("t6_r_frz", 32'(freeze), 0);
    chk("t6_r_stall", 32'(stall), 0); chk("t6_r_to", 32'(mem_timeout), 0);
    chk("t6_r_cnt", 32'(stall_cnt), 0);
    cyc(); quiet(); rst_n = 1;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
